// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/wb_watchdog.sv
// Per-transfer watchdog: counts BUSY cycles and flags the last allowed one.
// Latency: expired is combinational from the registered count.
// Backpressure: none; the counter saturates instead of wrapping.
module wb_watchdog #(
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TIMEOUT - 1'b1;

    logic [TO_W-1:0] cnt;

    // Count cycles while a transfer is outstanding; clear between transfers.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin bus arbiter with a slave watchdog and sticky error.
// Latency: request to s_STB is 1 cycle; ACK is passed through combinationally.
// Backpressure: a master holds STB until ACK; a silent slave is cut off after TIMEOUT cycles.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int              TO_W     = 16,
    parameter logic [TO_W-1:0] TIMEOUT  = 16'd1000,
    parameter logic [31:0]     ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_STB,
    input  logic        m0_WE,
    input  logic [31:0] m0_ADDR,
    input  logic [31:0] m0_DAT_I,
    output logic        m0_ACK,
    output logic [31:0] m0_DAT_O,
    input  logic        m1_STB,
    input  logic        m1_WE,
    input  logic [31:0] m1_ADDR,
    input  logic [31:0] m1_DAT_I,
    output logic        m1_ACK,
    output logic [31:0] m1_DAT_O,
    output logic        s_STB,
    output logic        s_WE,
    output logic [31:0] s_ADDR,
    output logic [31:0] s_DAT_O,
    input  logic        s_ACK,
    input  logic [31:0] s_DAT_I,
    input  logic        err_clr,
    output logic [1:0]  grant,
    output logic        err,
    output logic        err_master
);

    state_t      state, state_nx;
    logic [1:0]  grant_nx;
    logic        last, last_nx;
    logic        err_nx, err_master_nx;
    logic [1:0]  winner;
    logic        busy, g_sel, g_stb, g_we;
    logic [31:0] g_addr, g_dat;
    logic        expired, done, tmo, ack;
    logic [31:0] rdat;

    // last holds the index of the previous winner, so a tie goes to the other master.
    assign winner = (m0_STB && m1_STB) ? (last ? GNT_M0 : GNT_M1)
                  : (m0_STB ? GNT_M0 : GNT_M1);

    assign busy   = (state == BUSY);
    assign g_sel  = grant[1];
    assign g_stb  = g_sel ? m1_STB   : m0_STB;
    assign g_we   = g_sel ? m1_WE    : m0_WE;
    assign g_addr = g_sel ? m1_ADDR  : m0_ADDR;
    assign g_dat  = g_sel ? m1_DAT_I : m0_DAT_I;

    assign done = busy && g_stb && s_ACK;
    assign tmo  = busy && g_stb && !s_ACK && expired;
    assign ack  = done || tmo;
    assign rdat = done ? s_DAT_I : (tmo ? ERR_DATA : 32'h0);

    wb_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy),
        .run     (busy),
        .expired (expired)
    );

    // Arbitration state, round-robin history and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_NONE;
            last       <= 1'b1;
            err        <= 1'b0;
            err_master <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last       <= last_nx;
            err        <= err_nx;
            err_master <= err_master_nx;
        end
    end

    // Next-state: grant on any request, release on ACK, abort or timeout.
    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_nx       = last;
        err_nx        = err_clr ? 1'b0 : err;
        err_master_nx = err_master;
        case (state)
            IDLE: begin
                if (m0_STB || m1_STB) begin
                    state_nx = BUSY;
                    grant_nx = winner;
                    last_nx  = (winner == GNT_M1);
                end
            end
            BUSY: begin
                if (!g_stb || s_ACK) begin
                    state_nx = IDLE;
                    grant_nx = GNT_NONE;
                end else if (expired) begin
                    // A new timeout overrides a simultaneous err_clr.
                    state_nx      = IDLE;
                    grant_nx      = GNT_NONE;
                    err_nx        = 1'b1;
                    err_master_nx = g_sel;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = GNT_NONE;
            end
        endcase
    end

    // Slave-side forwarding and ACK/data return to the owner only.
    always_comb begin
        s_STB    = busy && g_stb;
        s_WE     = busy && g_we;
        s_ADDR   = busy ? g_addr : 32'h0;
        s_DAT_O  = busy ? g_dat  : 32'h0;
        m0_ACK   = ack && (grant == GNT_M0);
        m1_ACK   = ack && (grant == GNT_M1);
        m0_DAT_O = (grant == GNT_M0) ? rdat : 32'h0;
        m1_DAT_O = (grant == GNT_M1) ? rdat : 32'h0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic.
// Expected outputs come from a transaction-level owner/age model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_wb_arbiter;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst, err_clr, s_ACK;
    logic [31:0] s_DAT_I;
    logic        mstb [2];
    logic        mwe  [2];
    logic [31:0] maddr[2];
    logic [31:0] mdat [2];

    logic        m0_ACK, m1_ACK, s_STB, s_WE, err, err_master;
    logic [31:0] m0_DAT_O, m1_DAT_O, s_ADDR, s_DAT_O;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    wb_arbiter #(
        .TO_W     (16),
        .TIMEOUT  (16'd4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_STB     (mstb[0]),
        .m0_WE      (mwe[0]),
        .m0_ADDR    (maddr[0]),
        .m0_DAT_I   (mdat[0]),
        .m0_ACK     (m0_ACK),
        .m0_DAT_O   (m0_DAT_O),
        .m1_STB     (mstb[1]),
        .m1_WE      (mwe[1]),
        .m1_ADDR    (maddr[1]),
        .m1_DAT_I   (mdat[1]),
        .m1_ACK     (m1_ACK),
        .m1_DAT_O   (m1_DAT_O),
        .s_STB      (s_STB),
        .s_WE       (s_WE),
        .s_ADDR     (s_ADDR),
        .s_DAT_O    (s_DAT_O),
        .s_ACK      (s_ACK),
        .s_DAT_I    (s_DAT_I),
        .err_clr    (err_clr),
        .grant      (grant),
        .err        (err),
        .err_master (err_master)
    );

    // Reference model: owner (-1 = nobody), last winner, cycles already spent busy.
    int   owner, last, age;
    logic merr, mem;
    logic e_ack[2];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic sample();
        logic [1:0]  e_gnt;
        logic        e_sstb, e_swe;
        logic [31:0] e_addr, e_sdo;
        logic [31:0] e_dat[2];
        @(negedge clk);
        e_gnt = 2'b00; e_sstb = 1'b0; e_swe = 1'b0; e_addr = 32'h0; e_sdo = 32'h0;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_dat[0] = 32'h0; e_dat[1] = 32'h0;
        if (owner >= 0) begin
            e_gnt  = (owner == 0) ? 2'b01 : 2'b10;
            e_sstb = mstb[owner];
            e_swe  = mwe[owner];
            e_addr = maddr[owner];
            e_sdo  = mdat[owner];
            if (mstb[owner] && s_ACK) begin
                e_ack[owner] = 1'b1;
                e_dat[owner] = s_DAT_I;
            end else if (mstb[owner] && age == TMO - 1) begin
                e_ack[owner] = 1'b1;
                e_dat[owner] = ERR;
            end
        end
        chk("grant",      32'(grant),      32'(e_gnt));
        chk("s_STB",      32'(s_STB),      32'(e_sstb));
        chk("s_WE",       32'(s_WE),       32'(e_swe));
        chk("s_ADDR",     s_ADDR,          e_addr);
        chk("s_DAT_O",    s_DAT_O,         e_sdo);
        chk("m0_ACK",     32'(m0_ACK),     32'(e_ack[0]));
        chk("m0_DAT_O",   m0_DAT_O,        e_dat[0]);
        chk("m1_ACK",     32'(m1_ACK),     32'(e_ack[1]));
        chk("m1_DAT_O",   m1_DAT_O,        e_dat[1]);
        chk("err",        32'(err),        32'(merr));
        chk("err_master", 32'(err_master), 32'(mem));
    endtask

    task automatic advance();
        logic timed_out;
        @(posedge clk);
        timed_out = 1'b0;
        if (rst) begin
            owner = -1; last = 1; age = 0; merr = 1'b0; mem = 1'b0;
        end else begin
            if (owner < 0) begin
                if (mstb[0] || mstb[1]) begin
                    owner = (mstb[0] && mstb[1]) ? 1 - last : (mstb[0] ? 0 : 1);
                    last  = owner;
                    age   = 0;
                end
            end else if (!mstb[owner] || s_ACK) begin
                owner = -1;
            end else if (age == TMO - 1) begin
                timed_out = 1'b1;
                mem   = (owner == 1);
                owner = -1;
            end else begin
                age++;
            end
            merr = timed_out ? 1'b1 : (err_clr ? 1'b0 : merr);
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    logic [1:0] seq[6];

    initial begin
        owner = -1; last = 1; age = 0; merr = 1'b0; mem = 1'b0;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        rst = 1'b1; err_clr = 1'b0; s_ACK = 1'b0; s_DAT_I = 32'h0;
        for (int i = 0; i < 2; i++) begin
            mstb[i] = 1'b0; mwe[i] = 1'b0; maddr[i] = 32'h0; mdat[i] = 32'h0;
        end
        advance();
        step();
        sample();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_STB", 32'(s_STB), 32'h0);
        advance();

        // Single read with ACK tied high.
        rst = 1'b0; mstb[0] = 1'b1; maddr[0] = 32'h10; s_ACK = 1'b1; s_DAT_I = 32'hCAFE0001;
        sample();
        chk("single_idle_grant", 32'(grant), 32'h0);
        advance();
        sample();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_s_ADDR", s_ADDR, 32'h10);
        chk("single_ack", 32'(m0_ACK), 32'h1);
        chk("single_data", m0_DAT_O, 32'hCAFE0001);
        advance();
        mstb[0] = 1'b0;
        sample();
        chk("single_release", 32'(grant), 32'h0);
        advance();

        // Contention from reset: m0 first, then alternation.
        rst = 1'b1; step(); rst = 1'b0;
        mstb[0] = 1'b1; mstb[1] = 1'b1; maddr[0] = 32'hA0; maddr[1] = 32'hB0;
        seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        for (int k = 0; k < 6; k++) begin
            sample();
            chk("contend_grant", 32'(grant), 32'(seq[k]));
            advance();
        end
        mstb[0] = 1'b0; mstb[1] = 1'b0;
        step();

        // Timeout on m1, then clear the sticky error.
        s_ACK = 1'b0; mstb[1] = 1'b1; mwe[1] = 1'b0; maddr[1] = 32'h200;
        step();
        for (int k = 0; k < TMO; k++) begin
            sample();
            chk("tmo_ack", 32'(m1_ACK), (k == TMO - 1) ? 32'h1 : 32'h0);
            if (k == TMO - 1) chk("tmo_data", m1_DAT_O, 32'hDEADBEEF);
            advance();
        end
        mstb[1] = 1'b0;
        sample();
        chk("tmo_err", 32'(err), 32'h1);
        chk("tmo_err_master", 32'(err_master), 32'h1);
        err_clr = 1'b1;
        advance();
        err_clr = 1'b0;
        sample();
        chk("clr_err", 32'(err), 32'h0);
        chk("clr_err_master", 32'(err_master), 32'h1);
        advance();

        // Real ACK arriving in the last allowed cycle is a normal completion.
        mstb[0] = 1'b1; maddr[0] = 32'h40;
        step();
        step(); step(); step();
        s_ACK = 1'b1; s_DAT_I = 32'h5;
        sample();
        chk("limit_ack", 32'(m0_ACK), 32'h1);
        chk("limit_data", m0_DAT_O, 32'h5);
        advance();
        mstb[0] = 1'b0; s_ACK = 1'b0;
        sample();
        chk("limit_no_err", 32'(err), 32'h0);
        advance();

        // Abort: granted master drops STB while the slave is silent.
        mstb[0] = 1'b1;
        step();
        mstb[0] = 1'b0;
        sample();
        chk("abort_s_STB", 32'(s_STB), 32'h0);
        chk("abort_no_ack", 32'(m0_ACK), 32'h0);
        advance();
        sample();
        chk("abort_grant", 32'(grant), 32'h0);
        chk("abort_no_err", 32'(err), 32'h0);
        advance();

        // Reset in the middle of an m0 transfer resets round-robin history.
        mstb[0] = 1'b1;
        step();
        rst = 1'b1;
        sample();
        chk("rstmid_no_ack", 32'(m0_ACK), 32'h0);
        advance();
        rst = 1'b0; mstb[1] = 1'b1;
        sample();
        chk("rstmid_grant", 32'(grant), 32'h0);
        chk("rstmid_s_STB", 32'(s_STB), 32'h0);
        advance();
        sample();
        chk("rstmid_m0_first", 32'(grant), 32'h1);
        advance();
        mstb[0] = 1'b0; mstb[1] = 1'b0;
        step();

        // Random protocol-compliant traffic.
        for (int c = 0; c < 1500; c++) begin
            sample();
            advance();
            for (int i = 0; i < 2; i++) begin
                if (e_ack[i]) begin
                    mstb[i] = 1'b0;
                end else if (mstb[i]) begin
                    if ($urandom_range(0, 99) < 3) mstb[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 35) begin
                    mstb[i]  = 1'b1;
                    mwe[i]   = 1'($urandom_range(0, 1));
                    maddr[i] = $urandom;
                    mdat[i]  = $urandom;
                end
            end
            s_ACK   = ($urandom_range(0, 99) < 40);
            s_DAT_I = $urandom;
            err_clr = ($urandom_range(0, 99) < 8);
            rst     = ($urandom_range(0, 99) < 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
